pc_fetch_ctrl: RTL and testbench

Parametrised program-counter and fetch-request unit for the IF stage of the 5-stage pipeline. It generalises the basic PC register in four ways: parametrised address width and reset vector, a valid/ack handshake toward instruction memory, branch redirection with a pending-redirect buffer, and exception flush. Its outputs drive the instruction-memory address port and the IF/ID pipeline register.

---
 rtl/pc_fetch_ctrl_if.sv | 27 ++
 rtl/pc_fetch_ctrl.sv | 95 +++++++++
 tb/tb_pc_fetch_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch port: address, chip enable and request out, accept back.
// The fetch unit is the master; instruction memory (or a bench) is the slave.
interface pc_fetch_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    logic [ADDR_W-1:0] pc;
    logic              ce;
    logic              req;
    logic              ack;
    logic              misaligned;

    modport master (
        output pc,
        output ce,
        output req,
        output misaligned,
        input  ack
    );

    modport slave (
        input  pc,
        input  ce,
        input  req,
        input  misaligned,
        output ack
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// IF-stage program counter: sequential fetch with valid/ack handshake, branch
// redirect (buffered when the current request is not accepted) and exception flush.
module pc_fetch_ctrl #(
    parameter int              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int              STALL_W   = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   flush_pc,
    input  logic                branch_flag,
    input  logic [ADDR_W-1:0]   branch_target,
    pc_fetch_ctrl_if.master     imem
);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              pend_valid_q, pend_valid_d;
    logic              ce_q;
    logic              misaligned_q;
    logic              req;
    logic              adv;

    // Only the IF bit of the pipeline stall vector matters here.
    logic unused_stall;
    assign unused_stall = ^stall[STALL_W-1:1];

    assign req = (state_q != OFF) && !stall[0] && !flush;
    assign adv = req && imem.ack;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;

        if (state_q == OFF) begin
            state_d = RUN;
        end else if (flush) begin
            pc_d         = flush_pc;
            pend_valid_d = 1'b0;
            state_d      = RUN;
        end else if (branch_flag && adv) begin
            pc_d         = branch_target;
            pend_valid_d = 1'b0;
            state_d      = RUN;
        end else if (branch_flag) begin
            // Newest unaccepted branch wins; an older buffered one is dropped.
            pend_pc_d    = branch_target;
            pend_valid_d = 1'b1;
            state_d      = HOLD;
        end else if (adv && state_q == HOLD) begin
            pc_d         = pend_pc_q;
            pend_valid_d = 1'b0;
            state_d      = RUN;
        end else if (adv) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= OFF;
            pc_q         <= RESET_VEC;
            pend_pc_q    <= '0;
            pend_valid_q <= 1'b0;
            ce_q         <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
            ce_q         <= 1'b1;
            misaligned_q <= |pc_d[1:0];
        end
    end

    assign imem.pc         = pc_q;
    assign imem.ce         = ce_q;
    assign imem.req        = req;
    assign imem.misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_pc_fetch_ctrl;

    localparam int          ADDR_W  = 32;
    localparam int          STALL_W = 6;
    localparam logic [31:0] RV      = 32'h0000_1000;

    logic               clk = 1'b0;
    logic               rst;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [ADDR_W-1:0]  flush_pc;
    logic               branch_flag;
    logic [ADDR_W-1:0]  branch_target;

    int checks = 0;
    int errors = 0;

    pc_fetch_ctrl_if #(.ADDR_W(ADDR_W)) imem ();

    pc_fetch_ctrl #(
        .ADDR_W   (ADDR_W),
        .RESET_VEC(RV),
        .STALL_W  (STALL_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .branch_flag  (branch_flag),
        .branch_target(branch_target),
        .imem         (imem)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: "on" = fetching enabled, pend_q = buffered redirect (0 or 1 entries).
    logic              m_started = 1'b0;
    logic              m_on;
    logic [31:0]       m_pc;
    logic              m_mis;
    logic [31:0]       pend_q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_on  = 1'b0;
            m_pc  = RV;
            m_mis = 1'b0;
            pend_q.delete();
            m_started = 1'b1;
        end else if (m_started) begin
            if (!m_on) begin
                m_on = 1'b1;
            end else begin
                bit advance;
                advance = !stall[0] && !flush && imem.ack;
                if (flush) begin
                    m_pc = flush_pc;
                    pend_q.delete();
                end else if (branch_flag && advance) begin
                    m_pc = branch_target;
                    pend_q.delete();
                end else if (branch_flag) begin
                    pend_q.delete();
                    pend_q.push_back(branch_target);
                end else if (advance) begin
                    if (pend_q.size() != 0) m_pc = pend_q.pop_front();
                    else                    m_pc = m_pc + 32'd4;
                end
            end
            m_mis = (m_pc % 4) != 0;
        end
    end

    // Compare process: mid-cycle, against the model.
    always @(negedge clk) begin
        if (m_started) begin
            check("pc",         imem.pc,         m_pc);
            check("ce",         {31'b0, imem.ce}, {31'b0, m_on});
            check("misaligned", {31'b0, imem.misaligned}, {31'b0, m_mis});
            check("req",        {31'b0, imem.req},
                  {31'b0, m_on && !stall[0] && !flush});
        end
    end

    task automatic drv(input logic r, input logic [STALL_W-1:0] st, input logic fl,
                       input logic [31:0] fpc, input logic br, input logic [31:0] bt,
                       input logic ak);
        rst = r; stall = st; flush = fl; flush_pc = fpc;
        branch_flag = br; branch_target = bt; imem.ack = ak;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ak);
        drv(1'b0, '0, 1'b0, 32'h0, 1'b0, 32'h0, ak);
    endtask

    task automatic branch(input logic [31:0] bt, input logic ak);
        drv(1'b0, '0, 1'b0, 32'h0, 1'b1, bt, ak);
    endtask

    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0; flush_pc = '0;
        branch_flag = 1'b0; branch_target = '0; imem.ack = 1'b1;

        // Reset then run
        repeat (2) begin
            drv(1'b1, '0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            check("rst_ce", {31'b0, imem.ce}, 32'd0);
            check("rst_pc", imem.pc, 32'h1000);
        end
        idle(1'b1);
        check("run_pc0", imem.pc, 32'h1000);
        check("run_ce",  {31'b0, imem.ce}, 32'd1);
        idle(1'b1); check("run_pc1", imem.pc, 32'h1004);
        idle(1'b1); check("run_pc2", imem.pc, 32'h1008);

        // Stall
        branch(32'h20, 1'b1); check("stall_setup", imem.pc, 32'h20);
        repeat (3) begin
            drv(1'b0, 6'b000001, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            check("stall_pc",  imem.pc, 32'h20);
            check("stall_req", {31'b0, imem.req}, 32'd0);
        end
        drv(1'b0, 6'b111110, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("stall_resume", imem.pc, 32'h24);

        // Branch held by no-ack
        branch(32'h40, 1'b1); check("br_setup", imem.pc, 32'h40);
        branch(32'h200, 1'b0); check("hold_pc0", imem.pc, 32'h40);
        repeat (2) begin idle(1'b0); check("hold_pc", imem.pc, 32'h40); end
        idle(1'b1); check("hold_target", imem.pc, 32'h200);
        idle(1'b1); check("hold_next",   imem.pc, 32'h204);

        // Flush over pending branch
        branch(32'h300, 1'b0); check("fl_setup", imem.pc, 32'h204);
        drv(1'b0, 6'b000001, 1'b1, 32'h180, 1'b0, 32'h0, 1'b0);
        check("flush_pc", imem.pc, 32'h180);
        idle(1'b1); check("flush_n1", imem.pc, 32'h184);
        idle(1'b1); check("flush_n2", imem.pc, 32'h188);

        // Wrap and misalignment
        branch(32'hFFFF_FFFC, 1'b1); check("wrap_setup", imem.pc, 32'hFFFF_FFFC);
        idle(1'b1); check("wrap_pc", imem.pc, 32'h0);
        branch(32'h102, 1'b1);
        check("mis_pc",  imem.pc, 32'h102);
        check("mis_flag", {31'b0, imem.misaligned}, 32'd1);
        idle(1'b1); check("mis_next", imem.pc, 32'h106);

        // Reset in HOLD
        branch(32'h500, 1'b0); check("rh_setup", imem.pc, 32'h106);
        drv(1'b1, '0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("rh_pc", imem.pc, RV);
        check("rh_ce", {31'b0, imem.ce}, 32'd0);
        idle(1'b1); check("rh_run0", imem.pc, RV);
        idle(1'b1); check("rh_run1", imem.pc, RV + 32'd4);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [STALL_W-1:0] st;
            logic [31:0]        t1, t2;
            st = STALL_W'($urandom);
            st[0] = ($urandom_range(0, 3) == 0);
            t1 = $urandom; t2 = $urandom;
            if ($urandom_range(0, 3) != 0) begin t1[1:0] = 2'b00; t2[1:0] = 2'b00; end
            drv($urandom_range(0, 59) == 0, st, $urandom_range(0, 19) == 0, t1,
                $urandom_range(0, 5) == 0, t2, $urandom_range(0, 2) != 0);
        end
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
